// File: rtl/zbus_chip_sequencer.sv
// Arbitrates two requesters onto the shared buffered chip bus and sequences
// setup/strobe/hold/recovery timing for each W5300 or SL811 access.
module zbus_chip_sequencer #(
  parameter int unsigned W_SETUP   = 1,
  parameter int unsigned W_STROBE  = 4,
  parameter int unsigned SL_SETUP  = 1,
  parameter int unsigned SL_STROBE = 6,
  parameter int unsigned HOLD      = 1,
  parameter int unsigned RECOVERY  = 2
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       r0_req,
  input  logic       r0_chip,
  input  logic       r0_we,
  input  logic [9:0] r0_addr,
  input  logic [7:0] r0_wdata,
  input  logic       r1_req,
  input  logic       r1_chip,
  input  logic       r1_we,
  input  logic [9:0] r1_addr,
  input  logic [7:0] r1_wdata,
  output logic       r0_done,
  output logic       r1_done,
  output logic [7:0] rdata,
  input  logic [7:0] bd_in,
  output logic [7:0] bd_out,
  output logic       bd_oe,
  output logic [9:0] w5300_addr,
  output logic       w5300_cs_n,
  output logic       sl811_cs_n,
  output logic       sl811_a0,
  output logic       brd_n,
  output logic       bwr_n,
  output logic       busy
);
  localparam int unsigned CW = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_RECOV  = 3'd4;

  logic [2:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          owner, owner_nx;
  logic          chip, chip_nx;
  logic          we, we_nx;
  logic          last_grant, last_grant_nx;
  logic [9:0]    addr, addr_nx;
  logic [7:0]    wdata, wdata_nx;
  logic [7:0]    rdata_nx, bd_out_nx;
  logic          done0_prev, done1_prev;
  logic          elig0, elig1, act_nx, strb_nx;
  logic          w5300_cs_n_nx, sl811_cs_n_nx, brd_n_nx, bwr_n_nx;
  logic          bd_oe_nx, r0_done_nx, r1_done_nx, busy_nx;

  // Next state, latched transaction and next registered outputs
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    owner_nx      = owner;
    chip_nx       = chip;
    we_nx         = we;
    last_grant_nx = last_grant;
    addr_nx       = addr;
    wdata_nx      = wdata;
    rdata_nx      = rdata;
    // A done in the previous cycle masks the requester while it drops req
    elig0         = r0_req & ~done0_prev;
    elig1         = r1_req & ~done1_prev;

    case (state)
      ST_IDLE: begin
        if (elig0 | elig1) begin
          owner_nx      = (elig0 & elig1) ? ~last_grant : elig1;
          last_grant_nx = owner_nx;
          chip_nx       = owner_nx ? r1_chip  : r0_chip;
          we_nx         = owner_nx ? r1_we    : r0_we;
          addr_nx       = owner_nx ? r1_addr  : r0_addr;
          wdata_nx      = owner_nx ? r1_wdata : r0_wdata;
          state_nx      = ST_SETUP;
          cnt_nx        = chip_nx ? CW'(SL_SETUP) : CW'(W_SETUP);
        end
      end
      ST_SETUP: begin
        if (cnt == CW'(1)) begin
          state_nx = ST_STROBE;
          cnt_nx   = chip ? CW'(SL_STROBE) : CW'(W_STROBE);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ST_STROBE: begin
        if (cnt == CW'(1)) begin
          if (!we) rdata_nx = bd_in;
          state_nx = ST_HOLD;
          cnt_nx   = CW'(HOLD);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == CW'(1)) begin
          state_nx = ST_RECOV;
          cnt_nx   = CW'(RECOVERY);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ST_RECOV: begin
        if (cnt == CW'(1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase

    act_nx        = (state_nx == ST_SETUP) || (state_nx == ST_STROBE) || (state_nx == ST_HOLD);
    strb_nx       = (state_nx == ST_STROBE);
    w5300_cs_n_nx = ~(act_nx & ~chip_nx);
    sl811_cs_n_nx = ~(act_nx & chip_nx);
    brd_n_nx      = ~(strb_nx & ~we_nx);
    bwr_n_nx      = ~(strb_nx & we_nx);
    bd_oe_nx      = act_nx & we_nx;
    bd_out_nx     = (act_nx & we_nx) ? wdata_nx : 8'h00;
    r0_done_nx    = (state_nx == ST_RECOV) && (cnt_nx == CW'(1)) && !owner_nx;
    r1_done_nx    = (state_nx == ST_RECOV) && (cnt_nx == CW'(1)) && owner_nx;
    busy_nx       = (state_nx != ST_IDLE);
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      chip       <= 1'b0;
      we         <= 1'b0;
      last_grant <= 1'b1;
      addr       <= '0;
      wdata      <= '0;
      done0_prev <= 1'b0;
      done1_prev <= 1'b0;
      rdata      <= '0;
      bd_out     <= '0;
      bd_oe      <= 1'b0;
      w5300_addr <= '0;
      w5300_cs_n <= 1'b1;
      sl811_cs_n <= 1'b1;
      sl811_a0   <= 1'b0;
      brd_n      <= 1'b1;
      bwr_n      <= 1'b1;
      r0_done    <= 1'b0;
      r1_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      owner      <= owner_nx;
      chip       <= chip_nx;
      we         <= we_nx;
      last_grant <= last_grant_nx;
      addr       <= addr_nx;
      wdata      <= wdata_nx;
      done0_prev <= r0_done;
      done1_prev <= r1_done;
      rdata      <= rdata_nx;
      bd_out     <= bd_out_nx;
      bd_oe      <= bd_oe_nx;
      w5300_addr <= addr_nx;
      w5300_cs_n <= w5300_cs_n_nx;
      sl811_cs_n <= sl811_cs_n_nx;
      sl811_a0   <= addr_nx[0];
      brd_n      <= brd_n_nx;
      bwr_n      <= bwr_n_nx;
      r0_done    <= r0_done_nx;
      r1_done    <= r1_done_nx;
      busy       <= busy_nx;
    end
  end
endmodule

// File: tb/tb_zbus_chip_sequencer.sv
// Directed bench for zbus_chip_sequencer: an access-offset model checked every
// cycle, plus literal timing expectations on a default and a rebuilt instance.
module tb_zbus_chip_sequencer;
  localparam int unsigned WS = 1, WST = 4, SS = 1, SST = 6, HLD = 1, REC = 2;

  logic fclk, rst;
  logic r0_req, r0_chip, r0_we, r1_req, r1_chip, r1_we;
  logic [9:0] r0_addr, r1_addr;
  logic [7:0] r0_wdata, r1_wdata, bd_in;
  logic r0_done, r1_done, bd_oe, w5300_cs_n, sl811_cs_n, sl811_a0, brd_n, bwr_n, busy;
  logic [7:0] rdata, bd_out;
  logic [9:0] w5300_addr;

  logic q0_req, q0_chip, q0_we, z_req, z_chip, z_we;
  logic [9:0] q0_addr, z_addr;
  logic [7:0] q0_wdata, z_wdata;
  logic x_r0_done, x_r1_done, x_bd_oe, x_w_cs_n, x_s_cs_n, x_a0, x_brd_n, x_bwr_n, x_busy;
  logic [7:0] x_rdata, x_bd_out;
  logic [9:0] x_w_addr;

  int tests = 0;
  int fails = 0;

  zbus_chip_sequencer dut (
    .fclk(fclk), .rst(rst),
    .r0_req(r0_req), .r0_chip(r0_chip), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_chip(r1_chip), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_done(r0_done), .r1_done(r1_done), .rdata(rdata), .bd_in(bd_in), .bd_out(bd_out),
    .bd_oe(bd_oe), .w5300_addr(w5300_addr), .w5300_cs_n(w5300_cs_n), .sl811_cs_n(sl811_cs_n),
    .sl811_a0(sl811_a0), .brd_n(brd_n), .bwr_n(bwr_n), .busy(busy)
  );

  zbus_chip_sequencer #(.SL_STROBE(2), .RECOVERY(1)) dut2 (
    .fclk(fclk), .rst(rst),
    .r0_req(q0_req), .r0_chip(q0_chip), .r0_we(q0_we), .r0_addr(q0_addr), .r0_wdata(q0_wdata),
    .r1_req(z_req), .r1_chip(z_chip), .r1_we(z_we), .r1_addr(z_addr), .r1_wdata(z_wdata),
    .r0_done(x_r0_done), .r1_done(x_r1_done), .rdata(x_rdata), .bd_in(bd_in), .bd_out(x_bd_out),
    .bd_oe(x_bd_oe), .w5300_addr(x_w_addr), .w5300_cs_n(x_w_cs_n), .sl811_cs_n(x_s_cs_n),
    .sl811_a0(x_a0), .brd_n(x_brd_n), .bwr_n(x_bwr_n), .busy(x_busy)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an access is described by its cycle offset k (1 = first cycle after grant)
  function automatic int su(input bit c); return c ? SS : WS; endfunction
  function automatic int st(input bit c); return c ? SST : WST; endfunction
  function automatic int alen(input bit c); return su(c) + st(c) + HLD + REC; endfunction

  bit m_act, m_own, m_chip, m_we, m_last, m_pd0, m_pd1, m_cd0, m_cd1, m_e0, m_e1;
  int m_k;
  logic [9:0] m_addr;
  logic [7:0] m_wd, m_rd;

  always @(posedge fclk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_k = 0; m_last = 1; m_rd = 8'h00; m_own = 0; m_chip = 0; m_we = 0;
      m_pd0 = 0; m_pd1 = 0; m_cd0 = 0; m_cd1 = 0; m_addr = '0; m_wd = '0;
    end else begin
      if (m_act) begin
        if (!m_we && m_k == su(m_chip) + st(m_chip)) m_rd = bd_in;
        m_k++;
        if (m_k > alen(m_chip)) m_act = 0;
      end else begin
        m_e0 = r0_req && !m_pd0;
        m_e1 = r1_req && !m_pd1;
        if (m_e0 || m_e1) begin
          m_own  = (m_e0 && m_e1) ? !m_last : m_e1;
          m_last = m_own;
          m_chip = m_own ? r1_chip : r0_chip;
          m_we   = m_own ? r1_we : r0_we;
          m_addr = m_own ? r1_addr : r0_addr;
          m_wd   = m_own ? r1_wdata : r0_wdata;
          m_act  = 1; m_k = 1;
        end
      end
      m_pd0 = m_cd0; m_pd1 = m_cd1;
      m_cd0 = m_act && m_k == alen(m_chip) && !m_own;
      m_cd1 = m_act && m_k == alen(m_chip) && m_own;
    end
  end

  bit e_cs, e_stb;
  always @(negedge fclk) begin
    e_cs  = m_act && m_k <= su(m_chip) + st(m_chip) + HLD;
    e_stb = m_act && m_k > su(m_chip) && m_k <= su(m_chip) + st(m_chip);
    check("w5300_cs_n", int'(w5300_cs_n), int'(!(e_cs && !m_chip)));
    check("sl811_cs_n", int'(sl811_cs_n), int'(!(e_cs && m_chip)));
    check("brd_n", int'(brd_n), int'(!(e_stb && !m_we)));
    check("bwr_n", int'(bwr_n), int'(!(e_stb && m_we)));
    check("bd_oe", int'(bd_oe), int'(e_cs && m_we));
    check("busy", int'(busy), int'(m_act));
    check("r0_done", int'(r0_done), int'(m_cd0));
    check("r1_done", int'(r1_done), int'(m_cd1));
    check("rdata", int'(rdata), int'(m_rd));
    if (e_cs) begin
      check("w5300_addr", int'(w5300_addr), int'(m_addr));
      check("sl811_a0", int'(sl811_a0), int'(m_addr[0]));
      if (m_we) check("bd_out", int'(bd_out), int'(m_wd));
    end
  end

  // Observe one access on dut (sel=0) or dut2 (sel=1), offsets counted from grant
  task automatic measure(input bit sel, input bit n, output int cs_lo, output int stb_lo,
                         output int stb_first, output int done_at, output int oe_cnt);
    int i;
    cs_lo = 0; stb_lo = 0; stb_first = -1; done_at = -1; oe_cnt = 0; i = 0;
    do begin @(negedge fclk); i++; end while (!(sel ? x_busy : busy) && i < 40);
    if (!(sel ? x_busy : busy)) begin
      check("grant_timeout", 0, 1);
      return;
    end
    for (int k = 1; k <= 24 && done_at < 0; k++) begin
      if (!(sel ? x_w_cs_n : w5300_cs_n) || !(sel ? x_s_cs_n : sl811_cs_n)) cs_lo++;
      if (!(sel ? x_brd_n : brd_n) || !(sel ? x_bwr_n : bwr_n)) begin
        stb_lo++;
        if (stb_first < 0) stb_first = k;
      end
      if (sel ? x_bd_oe : bd_oe) oe_cnt++;
      if (sel ? (n ? x_r1_done : x_r0_done) : (n ? r1_done : r0_done)) done_at = k;
      if (done_at < 0) @(negedge fclk);
    end
    if (done_at < 0) check("done_timeout", 0, 1);
  endtask

  int cs_lo, stb_lo, stb_first, done_at, oe_cnt, idle_run, max_idle, nd, busy_seen;
  int seq[4];

  initial begin
    rst = 0;
    {r0_req, r0_chip, r0_we, r1_req, r1_chip, r1_we} = '0;
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0; bd_in = 8'h00;
    {q0_req, q0_chip, q0_we, z_req, z_chip, z_we} = '0;
    q0_addr = '0; z_addr = '0; q0_wdata = '0; z_wdata = '0;
    #1 rst = 1;
    repeat (2) @(negedge fclk);
    check("rst_cs_w", int'(w5300_cs_n), 1);
    check("rst_rdata", int'(rdata), 0);
    check("rst_addr", int'(w5300_addr), 0);
    @(posedge fclk); #2 rst = 0;

    // r0 write to W5300
    @(posedge fclk); #2;
    r0_chip = 0; r0_we = 1; r0_addr = 10'h155; r0_wdata = 8'hA5; r0_req = 1;
    measure(0, 0, cs_lo, stb_lo, stb_first, done_at, oe_cnt);
    check("t1_cs_lo", cs_lo, 6);
    check("t1_bwr_lo", stb_lo, 4);
    check("t1_bwr_first", stb_first, 2);
    check("t1_oe", oe_cnt, 6);
    check("t1_done_at", done_at, 8);
    check("t1_addr", int'(w5300_addr), 'h155);
    @(posedge fclk); #2 r0_req = 0;

    // r1 read from SL811
    repeat (2) @(posedge fclk); #2;
    r1_chip = 1; r1_we = 0; r1_addr = 10'h001; bd_in = 8'h3C; r1_req = 1;
    measure(0, 1, cs_lo, stb_lo, stb_first, done_at, oe_cnt);
    check("t2_cs_lo", cs_lo, 8);
    check("t2_brd_lo", stb_lo, 6);
    check("t2_oe", oe_cnt, 0);
    check("t2_done_at", done_at, 10);
    check("t2_rdata", int'(rdata), 'h3C);
    check("t2_a0", int'(sl811_a0), 1);
    @(posedge fclk); #2 r1_req = 0;

    // both held continuously: alternation and single idle gap
    repeat (2) @(posedge fclk); #2;
    r0_chip = 0; r0_we = 1; r0_addr = 10'h2AA; r0_wdata = 8'h5A;
    r1_chip = 1; r1_we = 0; r1_addr = 10'h002; bd_in = 8'h77;
    r0_req = 1; r1_req = 1;
    nd = 0; idle_run = 0; max_idle = 0; busy_seen = 0;
    for (int c = 0; c < 200 && nd < 4; c++) begin
      @(negedge fclk);
      if (r0_done) begin seq[nd] = 0; nd++; end
      if (r1_done) begin seq[nd] = 1; nd++; end
      if (!busy) idle_run++;
      else begin
        if (busy_seen != 0 && idle_run > max_idle) max_idle = idle_run;
        busy_seen = 1; idle_run = 0;
      end
    end
    @(posedge fclk); #2 r0_req = 0; r1_req = 0;
    check("t3_ndone", nd, 4);
    for (int j = 0; j < 4; j++) check("t3_order", seq[j], j % 2);
    check("t3_max_idle", max_idle, 1);
    check("t3_rdata", int'(rdata), 'h77);

    // reset during strobe aborts; held request is granted anew
    repeat (3) @(posedge fclk); #2;
    r0_chip = 0; r0_we = 1; r0_addr = 10'h0C3; r0_wdata = 8'h81; r0_req = 1;
    for (int c = 0; c < 20 && bwr_n; c++) @(negedge fclk);
    check("t4_in_strobe", int'(bwr_n), 0);
    #1 rst = 1;
    #1;
    check("t4_rst_bwr", int'(bwr_n), 1);
    check("t4_rst_cs", int'(w5300_cs_n), 1);
    check("t4_rst_oe", int'(bd_oe), 0);
    check("t4_rst_busy", int'(busy), 0);
    repeat (2) @(posedge fclk); #2 rst = 0;
    measure(0, 0, cs_lo, stb_lo, stb_first, done_at, oe_cnt);
    check("t4_done_at", done_at, 8);
    check("t4_cs_lo", cs_lo, 6);
    @(posedge fclk); #2 r0_req = 0;

    // r0 keeps req one cycle past done: no second grant
    repeat (2) @(posedge fclk); #2;
    r0_chip = 0; r0_we = 0; r0_addr = 10'h0F0; bd_in = 8'h99; r0_req = 1;
    measure(0, 0, cs_lo, stb_lo, stb_first, done_at, oe_cnt);
    check("t5_done_at", done_at, 8);
    @(posedge fclk); #2;
    @(posedge fclk); #2 r0_req = 0;
    busy_seen = 0;
    repeat (20) begin @(negedge fclk); if (busy) busy_seen++; end
    check("t5_no_regrant", busy_seen, 0);
    check("t5_rdata", int'(rdata), 'h99);

    // rebuilt instance: SL_STROBE=2, RECOVERY=1
    @(posedge fclk); #2;
    q0_chip = 1; q0_we = 0; q0_addr = 10'h003; bd_in = 8'h42; q0_req = 1;
    measure(1, 0, cs_lo, stb_lo, stb_first, done_at, oe_cnt);
    check("t6_brd_lo", stb_lo, 2);
    check("t6_cs_lo", cs_lo, 4);
    check("t6_done_at", done_at, 5);
    check("t6_rdata", int'(x_rdata), 'h42);
    @(posedge fclk); #2 q0_req = 0;
    repeat (2) @(posedge fclk); #2;
    q0_chip = 0; q0_we = 1; q0_addr = 10'h1FE; q0_wdata = 8'hC3; q0_req = 1;
    measure(1, 0, cs_lo, stb_lo, stb_first, done_at, oe_cnt);
    check("t6_w_cs_lo", cs_lo, 6);
    check("t6_w_bwr_lo", stb_lo, 4);
    check("t6_w_done_at", done_at, 7);
    @(posedge fclk); #2 q0_req = 0;
    repeat (4) @(posedge fclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/zbus_chip_sequencer.md
Name: zbus_chip_sequencer

Overview:
- Shares the buffered chip bus (bd, brd_n, bwr_n, address lines) between two requesters and sequences each access to the W5300 or SL811.
- Requester 0 is normally the ZX-bus port decoder; requester 1 is normally the internal poller/DMA.
- Produces chip selects and strobe timing with per-chip setup/strobe/hold/recovery counts in fclk (48 MHz) cycles.
- Sits between the ZX-bus decode logic and the board chip pins in the CPLD top level.

Parameters:
- W_SETUP, 1, W5300 setup cycles (cs low, strobe high), range 1..15
- W_STROBE, 4, W5300 strobe-low cycles, range 1..15
- SL_SETUP, 1, SL811 setup cycles, range 1..15
- SL_STROBE, 6, SL811 strobe-low cycles, range 1..15
- HOLD, 1, cycles after strobe release with cs still asserted (both chips), range 1..15
- RECOVERY, 2, idle cycles with cs deasserted before the next grant, range 1..15

Ports:
- fclk  in  1  48 MHz clock
- rst  in  1  reset, asynchronous, active-high
- r0_req, r1_req  in  1  level request, held until the matching done
- r0_chip, r1_chip  in  1  0 = W5300, 1 = SL811
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_addr, r1_addr  in  10  chip address
- r0_wdata, r1_wdata  in  8  write data
- r0_done, r1_done  out  1  one-cycle completion pulse
- rdata  out  8  read data, valid with done
- bd_in  in  8  chip data bus input
- bd_out  out  8  chip data bus output
- bd_oe  out  1  drive enable for bd_out
- w5300_addr  out  10  latched address
- w5300_cs_n  out  1  W5300 chip select
- sl811_cs_n  out  1  SL811 chip select
- sl811_a0  out  1  latched addr[0]
- brd_n  out  1  buffered read strobe
- bwr_n  out  1  buffered write strobe
- busy  out  1  state is not IDLE

Behaviour:
- Reset (async, immediate):
  - state IDLE
  - w5300_cs_n = sl811_cs_n = brd_n = bwr_n = 1
  - bd_oe = 0; bd_out = 0; rdata = 0; w5300_addr = 0; sl811_a0 = 0
  - r0_done = r1_done = 0; busy = 0
  - last_grant = 1, so r0 wins the first tie.
- All outputs are registered. States are IDLE, SETUP, STROBE, HOLD, RECOV, with a 4-bit down-counter.
- IDLE:
  - Requester n is eligible when rn_req = 1 and rn_done was 0 in the previous cycle. This mask prevents a double grant while the requester drops req.
  - One eligible requester is granted. If both are eligible, the one not equal to last_grant is granted. last_grant is updated on each grant.
  - On grant, latch chip, we, addr, wdata and the owner; go to SETUP.
- SETUP (SETUP count of the selected chip):
  - Selected cs_n = 0; address driven.
  - If we = 1: bd_oe = 1 and bd_out = wdata.
- STROBE (STROBE count of the selected chip):
  - bwr_n = 0 if we = 1, otherwise brd_n = 0.
  - On a read, bd_in is captured into rdata at the clock edge that ends the last STROBE cycle.
- HOLD (HOLD cycles):
  - Strobes = 1; cs and bd_oe remain asserted.
- RECOV (RECOVERY cycles):
  - cs_n = 1; bd_oe = 0.
  - Owner's done = 1 during the last RECOV cycle only; next state is IDLE.
- Access length:
  - cs low for SETUP+STROBE+HOLD cycles.
  - Grant edge to done is SETUP+STROBE+HOLD+RECOVERY cycles.
  - At most one extra IDLE cycle between accesses.
- rdata holds until the next read completes; writes leave rdata unchanged.
- Only one cs_n is low at any time. brd_n and bwr_n are never low together. A strobe is never low while cs_n = 1.
- Request fields that change after grant are ignored. A requester that drops req mid-access still gets its done, and the access completes.
- rst asserted mid-access aborts the access with no done. After release, a still-high req is granted anew.

Test Plan:
- r0 write, W5300, addr 0x155, data 0xA5, defaults -> w5300_cs_n low 6 cycles; bwr_n low cycles 2-5 after grant; bd_oe = 1 with bd_out = 0xA5 for those 6 cycles; w5300_addr = 0x155; r0_done pulses once, 8 cycles after grant.
- r1 read, SL811, addr 0x001, bd_in = 0x3C -> sl811_cs_n low 8 cycles; brd_n low 6; sl811_a0 = 1; bd_oe = 0 throughout; rdata = 0x3C when r1_done pulses.
- r0 and r1 held high continuously -> grants alternate r0, r1, r0, r1; each done pulses once per access; at most 1 IDLE cycle between accesses; cs_n never both low.
- rst pulsed during STROBE -> all strobes/cs high and bd_oe = 0 in the same cycle; no done; after release the held req completes normally.
- r0 holds req one cycle past done -> exactly one access per request; no spurious second grant.
- SL_STROBE = 2, RECOVERY = 1 rebuild -> sl811 brd_n low exactly 2 cycles; done 5 cycles after grant; W5300 timing unchanged.
